// File: rtl/tff_pkg.sv
// Shared mode encodings for the T flip-flop counter bank.
package tff_pkg;

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_UP     = 2'b10;
    localparam logic [1:0] MODE_DOWN   = 2'b11;

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop with synchronous reset and parallel load; rst beats ld beats toggle.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic ld,
    input  logic ld_val,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= rst_val;
        end else if (ld) begin
            q <= ld_val;
        end else begin
            q <= q ^ t;
        end
    end

endmodule

// File: rtl/tff_counter.sv
// Bank of WIDTH T flip-flops acting as a masked toggle register or an up/down counter.
// No handshake: inputs are sampled on every rising edge and q/tc reflect them one edge later.
module tff_counter
    import tff_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] tmask,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc
);

    logic [WIDTH-1:0] t;
    logic             chain;
    logic             wrap;

    // Ripple chain: bit i toggles when all lower bits are ones (UP) or zeros (DOWN).
    always_comb begin
        t     = '0;
        chain = 1'b1;
        if (en) begin
            case (mode)
                MODE_TOGGLE: t = tmask;
                MODE_UP: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        t[i]  = chain;
                        chain = chain & q[i];
                    end
                end
                MODE_DOWN: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        t[i]  = chain;
                        chain = chain & ~q[i];
                    end
                end
                default: t = '0;
            endcase
        end
    end

    always_comb begin
        wrap = 1'b0;
        if (en) begin
            if (mode == MODE_UP) begin
                wrap = &q;
            end else if (mode == MODE_DOWN) begin
                wrap = ~|q;
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk    (clk),
            .rst    (rst),
            .rst_val(RESET_VAL[i]),
            .ld     (load),
            .ld_val (load_val[i]),
            .t      (t[i]),
            .q      (q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst || load) begin
            tc <= 1'b0;
        end else begin
            tc <= wrap;
        end
    end

    assign q_bar = ~q;

endmodule

// File: tb/tb_tff_counter.sv
// Directed bench for tff_counter: driver pushes expected {chk_b, tc, q} per edge, monitor pops and compares.
module tb_tff_counter;
    import tff_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [1:0]   mode = MODE_HOLD;
    logic [W-1:0] tmask = '0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] q, q_bar, q_b, q_bar_b;
    logic         tc, tc_b;

    int checks = 0;
    int failures = 0;

    // Entry layout: [5] check zero-reset instance, [4] tc, [3:0] q
    logic [W+1:0] exp_q[$];

    always #5 clk = ~clk;

    tff_counter #(.WIDTH(W), .RESET_VAL(4'b0101)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .tmask(tmask),
        .load(load), .load_val(load_val), .q(q), .q_bar(q_bar), .tc(tc)
    );

    tff_counter #(.WIDTH(W), .RESET_VAL(4'b0000)) dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .tmask(tmask),
        .load(load), .load_val(load_val), .q(q_b), .q_bar(q_bar_b), .tc(tc_b)
    );

    task automatic step(input logic r, input logic ld, input logic [W-1:0] lv,
                        input logic e, input logic [1:0] m, input logic [W-1:0] tm,
                        input logic [W-1:0] eq, input logic etc, input logic chk_b);
        @(negedge clk);
        rst = r; load = ld; load_val = lv; en = e; mode = m; tmask = tm;
        exp_q.push_back({chk_b, etc, eq});
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one expected entry is consumed per edge that had stimulus issued.
    always @(posedge clk) begin
        logic [W+1:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("q", q, e[W-1:0]);
            check("q_bar", q_bar, ~e[W-1:0]);
            check("tc", {3'b000, tc}, {3'b000, e[W]});
            if (e[W+1]) begin
                check("q_reset0", q_b, 4'b0000);
                check("tc_reset0", {3'b000, tc_b}, 4'b0000);
            end
        end
    end

    initial begin
        // Reset for two cycles
        step(1, 0, 4'h0, 0, MODE_HOLD, 4'h0, 4'b0101, 0, 1);
        step(1, 0, 4'h0, 0, MODE_HOLD, 4'h0, 4'b0101, 0, 1);
        // Load zero, then count up through the wrap
        step(0, 1, 4'h0, 0, MODE_HOLD, 4'h0, 4'h0, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            step(0, 0, 4'h0, 1, MODE_UP, 4'h0, 4'(i % 16), (i == 16), 0);
        end
        step(0, 0, 4'h0, 1, MODE_UP, 4'h0, 4'h1, 0, 0);
        // Load then count down through the wrap
        step(0, 1, 4'b0011, 1, MODE_DOWN, 4'h0, 4'b0011, 0, 0);
        step(0, 0, 4'h0, 1, MODE_DOWN, 4'h0, 4'd2, 0, 0);
        step(0, 0, 4'h0, 1, MODE_DOWN, 4'h0, 4'd1, 0, 0);
        step(0, 0, 4'h0, 1, MODE_DOWN, 4'h0, 4'd0, 0, 0);
        step(0, 0, 4'h0, 1, MODE_DOWN, 4'h0, 4'd15, 1, 0);
        step(0, 0, 4'h0, 1, MODE_HOLD, 4'h0, 4'd15, 0, 0);
        // Masked toggle
        step(0, 1, 4'h0, 0, MODE_HOLD, 4'h0, 4'h0, 0, 0);
        step(0, 0, 4'h0, 1, MODE_TOGGLE, 4'b1010, 4'b1010, 0, 0);
        step(0, 0, 4'h0, 1, MODE_TOGGLE, 4'b1010, 4'b0000, 0, 0);
        step(0, 0, 4'h0, 1, MODE_TOGGLE, 4'b0000, 4'b0000, 0, 0);
        step(0, 0, 4'h0, 1, MODE_TOGGLE, 4'b0000, 4'b0000, 0, 0);
        // Priority: load over count, reset over load, reset mid-count
        step(0, 1, 4'b1001, 1, MODE_UP, 4'h0, 4'b1001, 0, 0);
        step(1, 1, 4'b1110, 1, MODE_UP, 4'h0, 4'b0101, 0, 1);
        step(0, 1, 4'b0110, 0, MODE_HOLD, 4'h0, 4'b0110, 0, 0);
        step(0, 0, 4'h0, 1, MODE_UP, 4'h0, 4'b0111, 0, 0);
        step(1, 0, 4'h0, 1, MODE_UP, 4'h0, 4'b0101, 0, 1);
        // Load at all-ones while UP is enabled: no count, no wrap pulse
        step(0, 1, 4'hF, 1, MODE_UP, 4'h0, 4'hF, 0, 0);
        step(0, 1, 4'hF, 1, MODE_UP, 4'h0, 4'hF, 0, 0);
        // Hold: en=0 with UP at all-ones, then en=1 with HOLD
        step(0, 0, 4'h0, 0, MODE_UP, 4'h0, 4'hF, 0, 0);
        step(0, 0, 4'h0, 0, MODE_UP, 4'h0, 4'hF, 0, 0);
        step(0, 0, 4'h0, 0, MODE_UP, 4'h0, 4'hF, 0, 0);
        step(0, 0, 4'h0, 1, MODE_HOLD, 4'h0, 4'hF, 0, 0);
        step(0, 1, 4'b0011, 0, MODE_HOLD, 4'h0, 4'b0011, 0, 0);
        step(0, 0, 4'h0, 0, MODE_DOWN, 4'hF, 4'b0011, 0, 0);
        step(0, 0, 4'h0, 1, MODE_HOLD, 4'hF, 4'b0011, 0, 0);
        step(0, 0, 4'h0, 0, MODE_HOLD, 4'h0, 4'b0011, 0, 0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
